// File: rtl/gpio_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpio_port_if : request side of the CPU memory-mapped read/write bus |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface gpio_port_if;
    logic [15:0] read_addr;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_strobe;

    modport master (output read_addr, write_addr, write_data, write_strobe);
    modport slave  (input  read_addr, write_addr, write_data, write_strobe);
endinterface
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gpio_port : bidirectional GPIO with optional edge interrupts,      |
// |             built only when GPIO_IRQ_EN is defined. Rev 1.0        |
// +--------------------------------------------------------------------+
module gpio_port #(
    parameter int          WIDTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'h8100
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    gpio_port_if.slave            bus,
    output wire       [15:0]      read_data,
    input  wire logic [WIDTH-1:0] pins_in,
    output logic      [WIDTH-1:0] pins_out,
    output logic      [WIDTH-1:0] pins_oe,
    output logic                  irq
);
    localparam logic [2:0]  c_OFF_IN   = 3'd0;
    localparam logic [2:0]  c_OFF_OUT  = 3'd1;
    localparam logic [2:0]  c_OFF_DIR  = 3'd2;
    localparam logic [2:0]  c_OFF_STAT = 3'd3;
    localparam logic [2:0]  c_OFF_IEN  = 3'd4;
    localparam logic [2:0]  c_OFF_EDGE = 3'd5;
    localparam logic [15:0] c_NUM_REGS = 16'd6;

    logic [15:0]      w_roff;
    logic [15:0]      w_woff;
    logic             w_rsel;
    logic             w_wen;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd_raw;
    logic [15:0]      w_rd;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Offsets are taken modulo 2^16 so a window near the top of the map still decodes
    assign w_roff         = bus.read_addr - BASE_ADDR;
    assign w_woff         = bus.write_addr - BASE_ADDR;
    assign w_rsel         = (w_roff < c_NUM_REGS);
    assign w_wen          = bus.write_strobe && (w_woff < c_NUM_REGS);
    assign w_wdata        = bus.write_data[WIDTH-1:0];
    assign w_unused_wdata = ^bus.write_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= pins_in;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
            r_dir <= '0;
        end else if (w_wen) begin
            if (w_woff[2:0] == c_OFF_OUT) r_out <= w_wdata;
            if (w_woff[2:0] == c_OFF_DIR) r_dir <= w_wdata;
        end
    end

    assign pins_out = r_out;
    assign pins_oe  = r_dir;

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;

    assign w_event = (r_s2 & ~r_prev & ~r_edge) | (~r_s2 & r_prev & r_edge);
    assign w_clr   = (w_wen && (w_woff[2:0] == c_OFF_STAT)) ? w_wdata : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
            r_stat <= '0;
            r_ien  <= '0;
            r_edge <= '0;
        end else begin
            r_prev <= r_s2;
            // A new event overrides a same-cycle W1C on that bit
            r_stat <= (r_stat & ~w_clr) | (w_event & r_ien);
            if (w_wen && (w_woff[2:0] == c_OFF_IEN))  r_ien  <= w_wdata;
            if (w_wen && (w_woff[2:0] == c_OFF_EDGE)) r_edge <= w_wdata;
        end
    end

    assign irq = |r_stat;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd_raw = '0;
        case (w_roff[2:0])
            c_OFF_IN:   w_rd_raw = r_s2;
            c_OFF_OUT:  w_rd_raw = r_out;
            c_OFF_DIR:  w_rd_raw = r_dir;
`ifdef GPIO_IRQ_EN
            c_OFF_STAT: w_rd_raw = r_stat;
            c_OFF_IEN:  w_rd_raw = r_ien;
            c_OFF_EDGE: w_rd_raw = r_edge;
`endif
            default:    w_rd_raw = '0;
        endcase
        w_rd             = '0;
        w_rd[WIDTH-1:0]  = w_rd_raw;
    end

    assign read_data = w_rsel ? w_rd : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// Randomised check of gpio_port against a register/pin-history model, plus literal anchors.
`timescale 1ns/1ps
module tb_gpio_port;
    localparam int          W = 8;
    localparam logic [15:0] B = 16'h8100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpio_port_if bus ();
    wire  [15:0]  read_data;
    logic [W-1:0] pins_in;
    logic [W-1:0] pins_out;
    logic [W-1:0] pins_oe;
    logic         irq;

    gpio_port #(.WIDTH(W), .BASE_ADDR(B)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .bus      (bus),
        .read_data(read_data),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .pins_oe  (pins_oe),
        .irq      (irq)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: register contents plus the last three sampled pin values (newest first)
    logic [W-1:0] m_out, m_dir, m_stat, m_ien, m_edge;
    logic [W-1:0] ph [0:2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = '0; m_dir = '0; m_stat = '0; m_ien = '0; m_edge = '0;
            ph[0] = '0; ph[1] = '0; ph[2] = '0;
        end else begin : step
            logic [W-1:0] setv, clrv, wd;
            logic [15:0]  off;
            setv = '0;
            clrv = '0;
            for (int i = 0; i < W; i++) begin
                bit rose, fell;
                rose = (ph[2][i] == 1'b0) && (ph[1][i] == 1'b1);
                fell = (ph[2][i] == 1'b1) && (ph[1][i] == 1'b0);
                if (m_ien[i] && (m_edge[i] ? fell : rose)) setv[i] = 1'b1;
            end
            off = bus.write_addr - B;
            wd  = bus.write_data[W-1:0];
            if (bus.write_strobe && off < 16'd6) begin
                case (off)
                    16'd1: m_out = wd;
                    16'd2: m_dir = wd;
`ifdef GPIO_IRQ_EN
                    16'd3: clrv   = wd;
                    16'd4: m_ien  = wd;
                    16'd5: m_edge = wd;
`endif
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clrv) | setv;
            ph[2] = ph[1];
            ph[1] = ph[0];
            ph[0] = pins_in;
        end
    end

    function automatic logic [16:0] exp_read(input logic [15:0] a);
        logic [15:0] off;
        logic [15:0] v;
        off = a - B;
        v   = '0;
        case (off)
            16'd0: v[W-1:0] = ph[1];
            16'd1: v[W-1:0] = m_out;
            16'd2: v[W-1:0] = m_dir;
            16'd3: v[W-1:0] = m_stat;
            16'd4: v[W-1:0] = m_ien;
            16'd5: v[W-1:0] = m_edge;
            default: v = '0;
        endcase
        return {(off < 16'd6), v};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin : cmp
            logic [16:0] e;
            e = exp_read(bus.read_addr);
            n_vec++;
            if (e[16] && read_data !== e[15:0]) begin
                n_bad++;
                $display("FAIL cyc_read addr=%h got=%h exp=%h", bus.read_addr, read_data, e[15:0]);
            end
            if (!e[16] && !(read_data === 16'hzzzz || read_data === 16'h0000)) begin
                n_bad++;
                $display("FAIL cyc_readz addr=%h got=%h exp=zzzz", bus.read_addr, read_data);
            end
            if (pins_out !== m_out || pins_oe !== m_dir || irq !== (|m_stat)) begin
                n_bad++;
                $display("FAIL cyc_outs got out=%h oe=%h irq=%b exp out=%h oe=%h irq=%b",
                         pins_out, pins_oe, irq, m_out, m_dir, |m_stat);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_z(input string nm);
        n_vec++;
        if (!(read_data === 16'hzzzz || read_data === 16'h0000)) begin
            n_bad++;
            $display("FAIL %s got=%h exp=zzzz", nm, read_data);
        end
    endtask

    task automatic rd(input logic [15:0] a, input string nm, input logic [15:0] exp);
        bus.read_addr = a;
        #1;
        chk(nm, read_data, exp);
    endtask

    // Issue one write on the next rising edge; returns 1 ns after that edge
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.write_addr   = a;
        bus.write_data   = d;
        bus.write_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.read_addr    = B;
        bus.write_addr   = '0;
        bus.write_data   = '0;
        bus.write_strobe = 1'b0;
        pins_in          = '0;
        chk_en           = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rd(B + 16'd1, "rst_out", 16'h0000);
        rd(B + 16'd2, "rst_dir", 16'h0000);
        rd(B + 16'd3, "rst_stat", 16'h0000);
        chk("rst_oe", 16'(pins_oe), 16'h0000);
        bus.read_addr = B + 16'd6;
        #1;
        chk_z("rst_hiz");
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        wr(B + 16'd1, 16'hA5C3);
        chk("out_c3", 16'(pins_out), 16'h00C3);
        wr(B + 16'd2, 16'h00FF);
        chk("oe_ff", 16'(pins_oe), 16'h00FF);
        rd(B + 16'd1, "rd_out", 16'h00C3);
        bus.read_addr = B + 16'd6;
        #1;
        chk_z("hiz_after_wr");

        pins_in = 8'h5A;
        bus.read_addr = B;
        edges(1);
        chk("in_edge1", read_data, 16'h0000);
        edges(1);
        chk("in_edge2", read_data, 16'h005A);

`ifdef GPIO_IRQ_EN
        pins_in = 8'h00;
        edges(3);
        wr(B + 16'd5, 16'h0000);
        wr(B + 16'd4, 16'h0001);
        bus.read_addr = B + 16'd3;
        pins_in = 8'h01;
        edges(2);
        chk("irq_edge2", 16'(irq), 16'h0000);
        edges(1);
        chk("irq_rise", 16'(irq), 16'h0001);
        chk("stat_rise", read_data, 16'h0001);
        wr(B + 16'd3, 16'h0001);
        chk("w1c_stat", read_data, 16'h0000);
        chk("w1c_irq", 16'(irq), 16'h0000);
        wr(B + 16'd5, 16'h0001);
        pins_in = 8'h00;
        edges(3);
        chk("stat_fall", read_data, 16'h0001);
        wr(B + 16'd3, 16'h0001);
        wr(B + 16'd5, 16'h0000);
        pins_in = 8'h01;
        edges(2);
        wr(B + 16'd3, 16'h0001);
        chk("set_wins", read_data, 16'h0001);
        wr(B + 16'd3, 16'h00FF);
        chk("clr_all", read_data, 16'h0000);
`else
        wr(B + 16'd4, 16'hFFFF);
        wr(B + 16'd5, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            pins_in = ~pins_in;
            edges(3);
            chk("noirq_irq", 16'(irq), 16'h0000);
        end
        rd(B + 16'd3, "noirq_stat", 16'h0000);
        rd(B + 16'd4, "noirq_ien", 16'h0000);
        rd(B + 16'd5, "noirq_edge", 16'h0000);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (c == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("async_rst_out", 16'(pins_out), 16'h0000);
                chk("async_rst_oe", 16'(pins_oe), 16'h0000);
                chk("async_rst_irq", 16'(irq), 16'h0000);
            end
            if (c == 1502) rst_n = 1'b1;
            if ($urandom_range(0, 3) == 0) pins_in = W'($urandom);
            bus.write_strobe = 1'($urandom_range(0, 1));
            bus.write_addr   = B + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) bus.write_addr = 16'($urandom);
            bus.write_data   = 16'($urandom);
            bus.read_addr    = B + 16'($urandom_range(0, 7));
        end
        @(negedge clk);
        bus.write_strobe = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gpio_port.md
# gpio_port

Parametrised bidirectional GPIO port on the CPU's memory-mapped bus, successor to the fixed 8-bit output-only GPIO. Provides per-pin direction control, output data, synchronised input readback and, optionally, per-pin edge-detect interrupts with sticky write-1-to-clear status. It sits on the shared read/write bus alongside the other peripherals. Its read data is tri-stated whenever its address window is not selected.

## Interface
- WIDTH, 8, number of pins, legal 1..16
- BASE_ADDR, 16'h8100, first address of the 6-word register window
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- read_addr  input  16  bus read address
- read_data  output  16  read data; high-Z unless read_addr in BASE_ADDR..BASE_ADDR+5
- write_addr  input  16  bus write address
- write_data  input  16  bus write data
- write_strobe  input  1  write qualifier, one write per cycle it is high
- pins_in  input  WIDTH  raw asynchronous pin inputs
- pins_out  output  WIDTH  output data register
- pins_oe  output  WIDTH  output enable per pin, 1 = drive
- irq  output  1  OR of all interrupt status bits

## Operation
- Register map (offset from BASE_ADDR):
  - +0 IN: synchronised input, read-only, writes ignored
  - +1 OUT: output data, R/W
  - +2 DIR: output enable, R/W
  - +3 STAT: interrupt status, read; write 1 clears bit (W1C)
  - +4 IEN: per-pin interrupt enable, R/W
  - +5 EDGE: per-pin edge select, 0 = rising, 1 = falling, R/W
- Writes use write_data[WIDTH-1:0]; higher bits are ignored. Reads are zero-extended to 16 bits.
- Read path is combinational from read_addr; reads have no side effects.
- Input sync: s1 <= pins_in, s2 <= s1, prev <= s2. IN reads s2.
- Edge detect per bit i: rise = s2 & ~prev, fall = ~s2 & prev. The event is rise when EDGE[i]=0, fall when EDGE[i]=1.
- STAT[i] sets on the clock after an event while IEN[i]=1. It stays set until cleared.
- STAT clear: a write to +3 with write_data[i]=1 clears bit i.
- Simultaneous set event and W1C clear on the same bit: set wins.
- Clearing IEN[i] does not clear STAT[i].
- irq = |STAT, combinational from the status register.
- Reset (i_rst_n low, asynchronous): pins_out=0, pins_oe=0 (all inputs), s1/s2/prev=0, STAT=0, IEN=0, EDGE=0, irq=0.
  - read_data follows read_addr even in reset: the register contents above, or Z outside the window.
- A pin held high through reset release produces a rising event 2 clocks later. That event is only latched if IEN has already been set by then.

## Timing
- Register write: takes effect at the rising edge where write_strobe=1 and the address matches. pins_out/pins_oe change right after that edge (1-cycle latency).
- Pin to IN readback: the value is visible after the 2nd rising edge following the pin change.
- Pin to STAT/irq: asserted after the 3rd rising edge following the pin change.
- W1C clear: irq drops right after the clearing write edge, unless another status bit is still set or a new event lands in that same cycle.
- Reset assertion takes effect immediately, regardless of clock. Deassertion is sampled at clock edges.

## Configuration
- GPIO_IRQ_EN defined: STAT, IEN, EDGE, the prev stage and edge logic are all built. irq is driven as above.
- GPIO_IRQ_EN undefined: that logic is omitted and irq is tied 0.
  - +3..+5 read as 16'h0000 (still driven, not Z), and writes to them are ignored.
  - IN, OUT and DIR behave identically in both builds.

## Test plan
- Reset, then read +1, +2, +3 -> 16'h0000 each; pins_oe=0; read address BASE_ADDR+6 -> high-Z.
- WIDTH=8: write +1 = 16'hA5C3 and +2 = 16'h00FF -> pins_out=8'hC3 one cycle after the write, pins_oe=8'hFF; read +1 -> 16'h00C3.
- Drive pins_in=8'h5A -> read +0 returns 16'h005A starting after the 2nd rising edge, not before.
- IEN=8'h01, EDGE=0, pin0 0->1 -> STAT=16'h0001 and irq=1 after the 3rd edge; write +3 = 16'h0001 -> STAT=0, irq=0. Set EDGE=1 and pin0 1->0 -> STAT=16'h0001 again.
- Pin0 rising event arriving in the same cycle as a W1C of bit 0 -> STAT[0] remains 1.
- Build without GPIO_IRQ_EN: toggle pins with IEN written to 16'hFFFF -> irq stays 0; reads of +3, +4, +5 return 16'h0000.
